// File: rtl/bitscan_pkg.sv
// Shared helpers for the lowest-set-bit priority select and the arbiters built on it.
package bitscan_pkg;

  // Upper bound for callers of lsb_isolate; wider vectors must be split by the caller.
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int unsigned idx_width(input int unsigned width);
    return (clog2(width) > 0) ? clog2(width) : 1;
  endfunction

  function automatic logic [MaxWidth-1:0] lsb_isolate(input logic [MaxWidth-1:0] vec);
    return vec & (~vec + MaxWidth'(1));
  endfunction

endpackage

// File: rtl/bitscan_enc.sv
// One-hot to binary encoder built as an OR tree; a zero input encodes to zero.
module bitscan_enc
  import bitscan_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    index = '0;
    for (int k = 0; k < int'(IDX_W); k++) begin
      for (int n = 0; n < int'(WIDTH); n++) begin
        if (((n >> k) & 1) == 1) begin
          index[k] = index[k] | onehot[n];
        end
      end
    end
  end

endmodule

// File: rtl/bitscan.sv
// Lowest-set-bit isolate with binary index and any-request flag, optionally registered.
module bitscan
  import bitscan_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PIPELINE = 0,
  parameter int unsigned IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] sel,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [WIDTH-1:0] sel_d;
  logic [IDX_W-1:0] index_d;
  logic             any_d;

  // Written as an add so synthesis maps it onto the carry chain.
  assign sel_d = req & (~req + WIDTH'(1));
  assign any_d = |req;

  bitscan_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot (sel_d),
    .index  (index_d)
  );

  if (PIPELINE == 0) begin : gen_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign sel   = sel_d;
    assign index = index_d;
    assign any   = any_d;
  end else begin : gen_reg
    logic [WIDTH-1:0] sel_q;
    logic [IDX_W-1:0] index_q;
    logic             any_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sel_q   <= '0;
        index_q <= '0;
        any_q   <= 1'b0;
      end else begin
        sel_q   <= sel_d;
        index_q <= index_d;
        any_q   <= any_d;
      end
    end

    assign sel   = sel_q;
    assign index = index_q;
    assign any   = any_q;
  end

endmodule

// File: tb/tb_bitscan.sv
// Directed and random checks of bitscan across widths and both pipeline settings.
module tb_bitscan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Combinational, WIDTH=16
  logic [15:0] req16 = '0;
  logic [15:0] sel16;
  logic [3:0]  idx16;
  logic        any16;

  // Registered, WIDTH=16
  logic [15:0] preq = '0;
  logic [15:0] psel;
  logic [3:0]  pidx;
  logic        pany;

  // Width sweep
  logic [0:0]  r1 = '0;
  logic [0:0]  s1;
  logic [0:0]  i1;
  logic        a1;
  logic [1:0]  r2 = '0;
  logic [1:0]  s2;
  logic [0:0]  i2;
  logic        a2;
  logic [4:0]  r5 = '0;
  logic [4:0]  s5;
  logic [2:0]  i5;
  logic        a5;
  logic [32:0] r33 = '0;
  logic [32:0] s33;
  logic [5:0]  i33;
  logic        a33;

  bitscan #(.WIDTH(16), .PIPELINE(0)) dut (
    .clk(clk), .rst(rst), .req(req16), .sel(sel16), .index(idx16), .any(any16)
  );
  bitscan #(.WIDTH(16), .PIPELINE(1)) dut_p (
    .clk(clk), .rst(rst), .req(preq), .sel(psel), .index(pidx), .any(pany)
  );
  bitscan #(.WIDTH(1), .PIPELINE(0)) dut_w1 (
    .clk(clk), .rst(rst), .req(r1), .sel(s1), .index(i1), .any(a1)
  );
  bitscan #(.WIDTH(2), .PIPELINE(0)) dut_w2 (
    .clk(clk), .rst(rst), .req(r2), .sel(s2), .index(i2), .any(a2)
  );
  bitscan #(.WIDTH(5), .PIPELINE(0)) dut_w5 (
    .clk(clk), .rst(rst), .req(r5), .sel(s5), .index(i5), .any(a5)
  );
  bitscan #(.WIDTH(33), .PIPELINE(0)) dut_w33 (
    .clk(clk), .rst(rst), .req(r33), .sel(s33), .index(i33), .any(a33)
  );

  // Reference: scan upward from bit 0 and stop at the first one.
  function automatic void model(input logic [63:0] v, input int w, output logic [63:0] s,
                                output logic [31:0] idx, output logic a);
    s = '0;
    idx = '0;
    a = 1'b0;
    for (int n = 0; n < w; n++) begin
      if (!a && v[n] === 1'b1) begin
        s[n] = 1'b1;
        idx = n;
        a = 1'b1;
      end
    end
  endfunction

  task automatic test_directed();
    logic [15:0] vr [7] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0A50, 16'h0A40, 16'h0001, 16'h0300};
    logic [15:0] vs [7] = '{16'h8000, 16'h0000, 16'h0001, 16'h0010, 16'h0040, 16'h0001, 16'h0100};
    logic [3:0]  vi [7] = '{4'd15, 4'd0, 4'd0, 4'd4, 4'd6, 4'd0, 4'd8};
    logic        va [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      req16 = vr[i];
      #1;
      total++;
      if ({sel16, idx16, any16} !== {vs[i], vi[i], va[i]}) begin
        bad++;
        $display("FAIL directed req=%h: got sel=%h idx=%0d any=%b, want sel=%h idx=%0d any=%b",
                 vr[i], sel16, idx16, any16, vs[i], vi[i], va[i]);
      end
    end
  endtask

  task automatic test_random16();
    logic [63:0] es;
    logic [31:0] ei;
    logic        ea;
    int          local_bad;
    local_bad = 0;
    for (int i = 0; i < 20000; i++) begin
      req16 = 16'($urandom & $urandom & $urandom);
      #1;
      model(64'(req16), 16, es, ei, ea);
      total++;
      if ({sel16, idx16, any16} !== {es[15:0], ei[3:0], ea}) begin
        bad++;
        local_bad++;
        $display("FAIL random16 req=%h: got sel=%h idx=%0d any=%b, want sel=%h idx=%0d any=%b",
                 req16, sel16, idx16, any16, es[15:0], ei[3:0], ea);
      end
    end
    if (local_bad == 0) $display("PASS");
  endtask

  task automatic test_comb_ignores_rst();
    rst = 1'b1;
    req16 = 16'h0A50;
    @(posedge clk);
    #1;
    total++;
    if ({sel16, idx16, any16} !== {16'h0010, 4'd4, 1'b1}) begin
      bad++;
      $display("FAIL comb_rst: got sel=%h idx=%0d any=%b, want sel=0010 idx=4 any=1",
               sel16, idx16, any16);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    preq = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({psel, pidx, pany} !== 21'd0) begin
      bad++;
      $display("FAIL reset: got sel=%h idx=%0d any=%b, want all zero", psel, pidx, pany);
    end
    rst = 1'b0;
    #2;
    total++;
    if ({psel, pidx, pany} !== 21'd0) begin
      bad++;
      $display("FAIL reset_release_early: got sel=%h, want 0000 before next edge", psel);
    end
    @(posedge clk);
    #1;
    total++;
    if ({psel, pidx, pany} !== {16'h0001, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_release: got sel=%h idx=%0d any=%b, want sel=0001 idx=0 any=1",
               psel, pidx, pany);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vr [6] = '{16'h0A50, 16'h8000, 16'h0000, 16'h0A40, 16'h0006, 16'hF000};
    logic [15:0] vs [6] = '{16'h0010, 16'h8000, 16'h0000, 16'h0040, 16'h0002, 16'h1000};
    logic [3:0]  vi [6] = '{4'd4, 4'd15, 4'd0, 4'd6, 4'd1, 4'd12};
    logic        va [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] prev_sel;
    prev_sel = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      preq = vr[i];
      #1;
      total++;
      if (psel !== prev_sel) begin
        bad++;
        $display("FAIL pipe_hold step %0d: got sel=%h before edge, want %h", i, psel, prev_sel);
      end
      @(posedge clk);
      #1;
      total++;
      if ({psel, pidx, pany} !== {vs[i], vi[i], va[i]}) begin
        bad++;
        $display("FAIL pipe step %0d: got sel=%h idx=%0d any=%b, want sel=%h idx=%0d any=%b",
                 i, psel, pidx, pany, vs[i], vi[i], va[i]);
      end
      prev_sel = vs[i];
    end
  endtask

  task automatic test_midstream_reset();
    preq = 16'h0300;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({psel, pidx, pany} !== 21'd0) begin
      bad++;
      $display("FAIL midstream_reset: got sel=%h idx=%0d any=%b, want all zero",
               psel, pidx, pany);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({psel, pidx, pany} !== {16'h0100, 4'd8, 1'b1}) begin
      bad++;
      $display("FAIL after_midstream_reset: got sel=%h idx=%0d, want sel=0100 idx=8",
               psel, pidx);
    end
  endtask

  task automatic test_width_sweep();
    logic [63:0] es;
    logic [31:0] ei;
    logic        ea;
    for (int i = 0; i < 2000; i++) begin
      r1 = i[0:0];
      r2 = i[1:0];
      r5 = i[4:0];
      if (i == 0) r33 = 33'h1_0000_0000;
      else if (i == 1) r33 = '0;
      else if (i == 2) r33 = '1;
      else r33 = {1'($urandom), $urandom & $urandom & $urandom};
      #1;
      model(64'(r1), 1, es, ei, ea);
      total++;
      if ({s1, i1, a1} !== {es[0], 1'b0, ea} || s1 !== r1) begin
        bad++;
        $display("FAIL w1 req=%b: got sel=%b idx=%0d any=%b, want sel=%b idx=0 any=%b",
                 r1, s1, i1, a1, es[0], ea);
      end
      model(64'(r2), 2, es, ei, ea);
      total++;
      if ({s2, i2, a2} !== {es[1:0], ei[0], ea}) begin
        bad++;
        $display("FAIL w2 req=%b: got sel=%b idx=%0d any=%b, want sel=%b idx=%0d any=%b",
                 r2, s2, i2, a2, es[1:0], ei[0], ea);
      end
      model(64'(r5), 5, es, ei, ea);
      total++;
      if ({s5, i5, a5} !== {es[4:0], ei[2:0], ea}) begin
        bad++;
        $display("FAIL w5 req=%b: got sel=%b idx=%0d any=%b, want sel=%b idx=%0d any=%b",
                 r5, s5, i5, a5, es[4:0], ei[2:0], ea);
      end
      model(64'(r33), 33, es, ei, ea);
      total++;
      if ({s33, i33, a33} !== {es[32:0], ei[5:0], ea}) begin
        bad++;
        $display("FAIL w33 req=%h: got sel=%h idx=%0d any=%b, want sel=%h idx=%0d any=%b",
                 r33, s33, i33, a33, es[32:0], ei[5:0], ea);
      end
    end
  endtask

  initial begin
    test_directed();
    test_random16();
    test_comb_ignores_rst();
    test_reset();
    test_back_to_back();
    test_midstream_reset();
    test_width_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
